// File: rtl/fetchq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetchq_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ADDR_W  = 32;

   localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  npc;
   } fetchq_entry_t;

   function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(4);
   endfunction

endpackage

// File: rtl/fetchq_fifo.sv
// Circular-buffer storage for fetched entries; pointers wrap at DEPTH, clear empties it.
module fetchq_fifo
   import fetchq_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         push,
   input  fetchq_entry_t                push_data,
   input  logic                         pop,
   output fetchq_entry_t                head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fetchq_entry_t    mem_q [DEPTH];
   fetchq_entry_t    mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: PC, request credit, redirect flush and head presentation.
// Define FETCHQ_BYPASS_EN to present a response straight to decode when the queue is empty.
module fetch_queue
   import fetchq_pkg::*;
#(
   parameter int unsigned       DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        redirect,
   input  logic [ADDR_W-1:0]           redirect_pc,
   output logic                        imem_req,
   output logic [ADDR_W-1:0]           imem_addr,
   input  logic [INSTR_W-1:0]          imem_rdata,
   output logic [INSTR_W-1:0]          IF_ID_instr,
   output logic [ADDR_W-1:0]           IF_ID_npc,
   output logic                        if_valid,
   input  logic                        id_ready,
   output logic [$clog2(DEPTH+1)-1:0]  q_count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned OCC_W = CNT_W + 1;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic              inflight_q, inflight_d;
   fetchq_entry_t     last_q, last_d;

   fetchq_entry_t     fifo_head, resp, head;
   logic [CNT_W-1:0]  fifo_count;
   logic [OCC_W-1:0]  occ;
   logic              fifo_empty, resp_valid, bypass, valid, transfer, push, pop, req;

   always_comb begin
      resp.instr = imem_rdata;
      resp.npc   = pc_incr(req_addr_q);
      // A response landing during a redirect belongs to the old path.
      resp_valid = inflight_q & ~redirect;
      fifo_empty = (fifo_count == '0);
`ifdef FETCHQ_BYPASS_EN
      bypass     = fifo_empty & resp_valid;
`else
      bypass     = 1'b0;
`endif
      head = last_q;
      if (!fifo_empty) begin
         head = fifo_head;
      end else if (bypass) begin
         head = resp;
      end
      valid    = ~fifo_empty | bypass;
      transfer = valid & id_ready;
      push     = resp_valid & ~(bypass & id_ready);
      pop      = ~fifo_empty & id_ready;
      // Credit counts the slot freed by this cycle's handshake so a full stream has no bubbles.
      occ = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(transfer);
      req = reset & ~redirect & (occ < OCC_W'(DEPTH));

      pc_d = pc_q;
      if (redirect) begin
         pc_d = redirect_pc & ~ADDR_W'(3);
      end else if (req) begin
         pc_d = pc_incr(pc_q);
      end
      inflight_d = req;
      req_addr_d = req ? pc_q : req_addr_q;
      last_d     = head;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         inflight_q <= 1'b0;
         last_q     <= '0;
      end else begin
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         inflight_q <= inflight_d;
         last_q     <= last_d;
      end
   end

   fetchq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .clear     (redirect),
      .push      (push),
      .push_data (resp),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   assign imem_req    = req;
   assign imem_addr   = pc_q;
   assign IF_ID_instr = head.instr;
   assign IF_ID_npc   = head.npc;
   assign if_valid    = valid;
   assign q_count     = fifo_count;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 2; prefetch queue entries, legal range 2..8.
REQ-002 Parameter RESET_PC, default 32'h0000_0000; PC value loaded on reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 redirect  input  1  branch taken (EX/MEM PCSrc); flushes fetch.
REQ-006 redirect_pc  input  32  branch target (EX/MEM NPC).
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  instruction memory word address (byte address, bits[1:0]=00).
REQ-009 imem_rdata  input  32  read data, valid exactly one cycle after imem_req.
REQ-010 IF_ID_instr  output  32  instruction at queue head.
REQ-011 IF_ID_npc  output  32  head instruction's address + 4.
REQ-012 if_valid  output  1  head entry valid for decode.
REQ-013 id_ready  input  1  decode accepts head this cycle.
REQ-014 q_count  output  clog2(DEPTH+1)  current occupancy.

Function
REQ-015 PC register SHALL hold the next fetch address; imem_addr = PC.
REQ-016 imem_req SHALL assert iff (q_count + inflight) < DEPTH and redirect = 0; inflight = request issued previous cycle.
REQ-017 On an issued request, PC SHALL advance by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 Response SHALL be pushed as entry {imem_rdata, request address + 4} the cycle after the request, unless discarded.
REQ-019 Transfer SHALL occur when if_valid & id_ready; head then pops.
REQ-020 Simultaneous push and pop SHALL leave q_count unchanged; overflow SHALL be impossible by REQ-016 credit rule.
REQ-021 if_valid SHALL be 0 whenever q_count = 0 (except REQ-029); IF_ID_instr/IF_ID_npc SHALL hold last values when invalid.
REQ-022 Head outputs SHALL remain stable while if_valid & !id_ready.
REQ-023 On redirect in cycle N: PC := {redirect_pc[31:2], 2'b00} at edge N; queue emptied (q_count = 0 in N+1); in-flight response returning in N+1 discarded.
REQ-024 Handshake occurring in redirect cycle counts as completed for decode; flush still applies to all remaining entries.
REQ-025 Redirect latency: target request in N+1, data in N+2, if_valid in N+3 (N+2 with bypass).
REQ-026 Back-to-back redirects: the last one wins; no entry from a prior path SHALL reach decode.

Reset
REQ-027 While reset = 0: PC = RESET_PC, q_count = 0, inflight = 0, if_valid = 0, imem_req = 0, IF_ID_instr = 0, IF_ID_npc = 0; asserted asynchronously.
REQ-028 First request SHALL issue the first rising edge after reset deassertion; reset mid-operation SHALL discard all queue and in-flight state.

Configuration
REQ-029 Macro FETCHQ_BYPASS_EN defined: when queue empty and a valid response arrives, IF_ID_instr/IF_ID_npc/if_valid SHALL be driven combinationally from the response; if id_ready also high, the entry SHALL NOT be pushed.
REQ-030 Macro undefined: every response SHALL be pushed; if_valid earliest one cycle after response arrives.

Structure
REQ-031 Package fetchq_pkg SHALL hold RESET_PC default, instruction width constant (32), and the entry struct {instr, npc}.
REQ-032 Storage and read/write pointers SHALL be a single sub-module fetchq_fifo (circular buffer, pointers wrap at DEPTH); PC, credit, discard and bypass logic in fetch_queue.

Verification
REQ-033 Reset release, id_ready=1, imem returns addr as data: decode receives npc 4,8,12,... one per cycle after fill, no gaps.
REQ-034 id_ready=0 for 10 cycles, DEPTH=2: q_count saturates at 2, imem_req deasserts, head stable at instr@0, npc=4.
REQ-035 redirect=1, redirect_pc=32'h0000_0103 with full queue and request in flight: q_count=0 next cycle, imem_addr=32'h100, first delivered npc=32'h104, no stale entry.
REQ-036 RESET_PC=32'hFFFF_FFF8: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; npc of FFFF_FFFC entry = 0.
REQ-037 Reset asserted mid-stream with q_count=2: if_valid=0 and q_count=0 immediately, restart fetch at RESET_PC.
REQ-038 Bypass build, empty queue, id_ready=1: if_valid in same cycle as imem_rdata, q_count stays 0; non-bypass build: if_valid one cycle later.
